jb_predict_unit: RTL

- Parametrised successor to the decode-stage jump/branch resolution logic.
- Adds a direct-mapped branch target buffer (BTB), indexed by fetch PC, with a 2-bit saturating counter per entry. IF redirects speculatively from it.
- ID resolves each branch or jump, detects mispredicts, flushes IF, supplies the corrected PC, and trains the table.

---
 rtl/jb_predict_unit_if.sv | 30 +++
 rtl/jb_predict_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/jb_predict_unit_if.sv
// Fetch/decode-side bus of the jump/branch predictor: IF lookup, ID resolution and redirect.
interface jb_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            id_valid;
  logic            id_stall;
  logic            id_is_jump;
  logic [XLEN-1:0] id_pc;
  logic            id_taken;
  logic [XLEN-1:0] id_target;
  logic            id_pred_taken;
  logic [XLEN-1:0] id_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output if_pc, id_valid, id_stall, id_is_jump, id_pc, id_taken, id_target,
           id_pred_taken, id_pred_target,
    input  if_pred_taken, if_pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_is_jump, id_pc, id_taken, id_target,
           id_pred_taken, id_pred_target,
    output if_pred_taken, if_pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/jb_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: 0-cycle IF lookup, ID resolve/redirect, training on the next edge.
// Optional macro BTB_STATS_EN adds free-running lookup and mispredict counters.
module jb_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  jb_predict_unit_if.slave bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  generate
    if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
      $error("jb_predict_unit: ENTRIES must be a power of 2 and at least 2");
    end
  endgenerate

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [XLEN-1:0]  lk_seq;

  logic             resolve;
  logic [XLEN-1:0]  id_seq;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict_c;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_we;
  logic [XLEN-1:0]  up_target;
  logic [1:0]       up_ctr;

  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign lk_tag = bus.if_pc[XLEN-1:IDX_W+2];
  assign lk_seq = bus.if_pc + XLEN'(4);
  assign up_idx = bus.id_pc[IDX_W+1:2];
  assign up_tag = bus.id_pc[XLEN-1:IDX_W+2];
  assign id_seq = bus.id_pc + XLEN'(4);

  // IF lookup; reads the stored table only, so a same-cycle update is seen next cycle
  always_comb begin
    lk_hit             = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.if_pred_taken  = 1'b0;
    bus.if_pred_target = lk_seq;
    if (lk_hit && ctr_q[lk_idx][1]) begin
      bus.if_pred_taken  = 1'b1;
      bus.if_pred_target = target_q[lk_idx];
    end else begin
      bus.if_pred_taken  = 1'b0;
      bus.if_pred_target = lk_seq;
    end
  end

  // ID resolution: a stalled instruction neither flushes nor trains until released
  always_comb begin
    resolve      = bus.id_valid && !bus.id_stall && !rst;
    actual_next  = bus.id_taken ? bus.id_target : id_seq;
    mispredict_c = resolve && (bus.id_pred_target != actual_next);
    if (rst) begin
      bus.redirect_pc = id_seq;
    end else begin
      bus.redirect_pc = actual_next;
    end
    bus.mispredict = mispredict_c;
  end

  // Training decision for the entry addressed by the resolving instruction
  always_comb begin
    up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_we     = 1'b0;
    up_target = target_q[up_idx];
    up_ctr    = ctr_q[up_idx];
    if (!resolve) begin
      up_we = 1'b0;
    end else if (up_hit) begin
      up_we = 1'b1;
      if (bus.id_is_jump) begin
        up_ctr    = 2'b11;
        up_target = bus.id_target;
      end else if (bus.id_taken) begin
        up_ctr    = ctr_inc(ctr_q[up_idx]);
        up_target = bus.id_target;
      end else begin
        up_ctr    = ctr_dec(ctr_q[up_idx]);
      end
    end else if (bus.id_taken) begin
      // Allocation overwrites whatever aliased PC held this index
      up_we     = 1'b1;
      up_target = bus.id_target;
      up_ctr    = bus.id_is_jump ? 2'b11 : 2'b10;
    end else begin
      up_we = 1'b0;
    end
  end

  // Table storage; reset drops any update pending in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (up_we) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= up_target;
      ctr_q[up_idx]    <= up_ctr;
    end else begin
      valid_q[up_idx]  <= valid_q[up_idx];
    end
  end

`ifdef BTB_STATS_EN
  // Free-running statistics, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups     <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      if (mispredict_c) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end else begin
        stat_mispredicts <= stat_mispredicts;
      end
    end
  end
`endif

endmodule
